// File: rtl/tick_token_source.sv
// tick_token_source
//
// Turns each rising edge of an asynchronous, slowly toggling input (slow_clk)
// into a single-cycle tick in the clk_in domain. Every tick takes the next
// value of a wrapping token counter. The token is queued in a small output
// FIFO with a valid/ready handshake. A token that arrives while the FIFO is
// full and nothing is being popped is dropped, and a sticky overflow flag is
// raised.
//
// Optional feature: define TICK_TOKEN_SOURCE_DROP_CNT_EN to add an 8-bit
// saturating drop_count output that counts discarded tokens.

module tick_token_source #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int START = 0
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             slow_clk,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             overflow
`ifdef TICK_TOKEN_SOURCE_DROP_CNT_EN
   ,
   output logic [7:0]       drop_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [WIDTH-1:0] START_VAL  = WIDTH'(START);
   localparam logic [CW-1:0]    FULL_COUNT = CW'(DEPTH);

   // Edge detection on the synchronised slow clock
   logic sync1;
   logic sync2;
   logic prev;
   logic armed;
   logic [1:0] settle;
   logic tick;

   // Token counter and FIFO storage
   logic [WIDTH-1:0] token;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;

   // Handshake decode
   logic full;
   logic pop;
   logic push;
   logic drop;

   // The two synchronizer stages come out of reset as zero. That zero is not
   // a real observation of slow_clk. Arming therefore waits until sync2
   // carries a sampled value ('settle' reaches 2). A slow_clk held high
   // across reset release must first be seen low before it can tick.
   assign tick = sync2 & ~prev & armed;

   assign full = (count == FULL_COUNT);
   assign pop  = out_valid & out_ready;

   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push = tick & (~full | pop);
   assign drop = tick & full & ~pop;

   assign out_valid = (count != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

   // Synchronise slow_clk and keep the previous value for rise detection
   always_ff @(posedge clk_in) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= slow_clk;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   // Arm the edge detector once slow_clk has been genuinely observed low
   always_ff @(posedge clk_in) begin
      if (reset) begin
         settle <= 2'd0;
         armed  <= 1'b0;
      end else begin
         if (settle != 2'd2) begin
            settle <= settle + 2'd1;
         end
         if ((settle == 2'd2) && !sync2) begin
            armed <= 1'b1;
         end
      end
   end

   // Token counter advances on every tick, whether the token is kept or not
   always_ff @(posedge clk_in) begin
      if (reset) begin
         token <= START_VAL;
      end else if (tick) begin
         token <= token + WIDTH'(1);
      end
   end

   // FIFO storage write; the contents need no reset because count gates them
   always_ff @(posedge clk_in) begin
      if (!reset && push) begin
         mem[wr_ptr] <= token;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
   always_ff @(posedge clk_in) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow flag, raised by any discarded token
   always_ff @(posedge clk_in) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end
   end

`ifdef TICK_TOKEN_SOURCE_DROP_CNT_EN
   // Saturating count of discarded tokens
   always_ff @(posedge clk_in) begin
      if (reset) begin
         drop_count <= 8'd0;
      end else if (drop && (drop_count != 8'd255)) begin
         drop_count <= drop_count + 8'd1;
      end
   end
`endif

endmodule

// File: doc/tick_token_source.md
TICK_TOKEN_SOURCE -- requirements
Module: tick_token_source

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the token data width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the output FIFO entry count (power of 2, 2..16).
REQ-003 The module SHALL have parameter START, default 0, giving the first token value after reset.
REQ-004 The module SHALL have port clk_in, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port slow_clk, input, 1 bit: divided clock from the upstream clock divider, treated as asynchronous data.
REQ-007 The module SHALL have port out_ready, input, 1 bit: consumer ready.
REQ-008 The module SHALL have port out_valid, output, 1 bit: FIFO head valid.
REQ-009 The module SHALL have port out_data, output, WIDTH bits: FIFO head token.
REQ-010 The module SHALL have port overflow, output, 1 bit: sticky flag, set when a token is dropped.

Function
REQ-011 slow_clk SHALL pass through a 2-flop synchronizer (sync1, sync2) and a previous-value register (prev).
REQ-012 tick SHALL equal sync2 AND NOT prev AND armed, one clk_in cycle wide per slow_clk rising edge.
REQ-013 armed SHALL clear on reset and set on the first cycle with sync2 = 0, so a slow_clk that is already high at reset release produces no tick.
REQ-014 A token counter SHALL hold the next value, start at START, increment by 1 on every tick (accepted or dropped), and wrap from 2^WIDTH-1 to 0.
REQ-015 On tick with the FIFO not full, the current counter value SHALL be written to the FIFO at the next clk_in edge.
REQ-016 Latency: slow_clk first sampled high at edge E0 SHALL give out_valid = 1 after edge E2 when the FIFO was empty.
REQ-017 A pop SHALL occur on any edge where out_valid AND out_ready; out_data SHALL be the oldest unpopped token, in FIFO order.
REQ-018 out_valid SHALL equal (FIFO count != 0); out_data SHALL hold its value while out_valid = 1 and out_ready = 0.
REQ-019 Tick and pop in the same cycle with the FIFO not full: both SHALL occur and the count SHALL be unchanged.
REQ-020 Tick and pop in the same cycle with the FIFO full: the write SHALL be accepted (the pop frees the slot), with no drop.
REQ-021 Tick with the FIFO full and no pop: the token SHALL be discarded, the counter SHALL still increment, and overflow SHALL be set to 1.
REQ-022 FIFO read/write pointers SHALL wrap modulo DEPTH, and the count SHALL range 0..DEPTH.

Reset
REQ-023 While reset = 1 at an edge: sync1 = sync2 = prev = 0, armed = 0, counter = START, FIFO empty, out_valid = 0, overflow = 0, out_data = 0.
REQ-024 Reset SHALL override a concurrent tick or pop; reset mid-stream SHALL discard all queued tokens.

Configuration
REQ-025 Macro TICK_TOKEN_SOURCE_DROP_CNT_EN defined: the module SHALL add output port drop_count, 8 bits, cleared by reset, incremented on every dropped token, and saturating at 255.
REQ-026 Macro TICK_TOKEN_SOURCE_DROP_CNT_EN undefined: the drop_count port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-027 Bench SHALL cover basic flow: reset, out_ready = 1, 3 slow_clk pulses (period 20 clk_in) -> tokens 0, 1, 2 appear in order, each out_valid rising 3 edges after its slow_clk rise.
REQ-028 Bench SHALL cover backpressure: out_ready = 0, 6 pulses, DEPTH = 4 -> FIFO holds 0, 1, 2, 3; tokens 4 and 5 are dropped; overflow = 1; drop_count = 2 when the macro is defined; then out_ready = 1 -> pops 0, 1, 2, 3 and the next pulse yields 6.
REQ-029 Bench SHALL cover full plus simultaneous events: FIFO full, tick coincides with pop -> no drop, overflow stays 0, count stays 4.
REQ-030 Bench SHALL cover arming: slow_clk held high through reset release -> no token until slow_clk goes low then high, and the first token = START.
REQ-031 Bench SHALL cover wrap: WIDTH = 4, START = 14, 4 pulses -> tokens 14, 15, 0, 1.
REQ-032 Bench SHALL cover mid-stream reset: reset asserted with 2 tokens queued -> next edge out_valid = 0 and overflow = 0, and after re-arming the next token = START.
